fifo_read_ctrl: RTL and testbench

- Read-side controller for the team's synchronous FIFO (w_en/r_en, registered dout, 6-bit occupancy counter).
- Decides when to drain the FIFO and issues r_en without ever reading while empty.
- Absorbs the FIFO's one-cycle read latency and presents the data as a valid/ready stream in bursts, with m_last on the final beat.
- Sits between the FIFO and any downstream consumer (e.g. a serializer or bus master).

---
 rtl/fifo_read_ctrl_pkg.sv | 6 +
 rtl/fifo_read_ctrl_if.sv | 16 +
 rtl/fifo_read_ctrl_skid_buf.sv | 53 +++++
 rtl/fifo_read_ctrl.sv | 79 +++++++
 tb/tb_fifo_read_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_read_ctrl_pkg.sv
// fifo_rd_pkg: shared types and constants for the FIFO read-side controller
package fifo_rd_pkg;
    localparam int FIFO_DEPTH = 32;
    localparam int CNT_W = 6;
    typedef enum logic [1:0] {IDLE, BURST, WAIT_DRAIN} state_t;
endpackage

// File: rtl/fifo_read_ctrl_if.sv
// fifo_read_ctrl_if: FIFO read port plus valid/ready burst stream
interface fifo_read_ctrl_if #(parameter int N = 16);
    import fifo_rd_pkg::*;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [N-1:0]     fifo_dout;
    logic             fifo_r_en;
    logic             m_valid;
    logic             m_ready;
    logic [N-1:0]     m_data;
    logic             m_last;
    modport master(input fifo_empty, fifo_count, fifo_dout, m_ready,
                   output fifo_r_en, m_valid, m_data, m_last);
    modport slave(output fifo_empty, fifo_count, fifo_dout, m_ready,
                  input fifo_r_en, m_valid, m_data, m_last);
endinterface

// File: rtl/fifo_read_ctrl_skid_buf.sv
// frc_skid_buf: 2-entry output buffer holding FIFO read data with its last-beat tag
module frc_skid_buf #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         push_last,
    input  logic [N-1:0] push_data,
    input  logic         pop,
    output logic [1:0]   occ,
    output logic [N-1:0] head_data,
    output logic         head_last
);
    logic [N-1:0] d0, d1;
    logic         l0, l1;
    assign head_data = d0;
    assign head_last = l0 && occ != 2'd0;
    // entry 0 is always the head; pop shifts entry 1 forward, push fills the first free slot
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            occ <= '0;
            d0  <= '0;
            d1  <= '0;
            l0  <= 1'b0;
            l1  <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        d0 <= push_data;
                        l0 <= push_last;
                    end else begin
                        d1 <= push_data;
                        l1 <= push_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    d0  <= d1;
                    l0  <= l1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    d0 <= occ == 2'd1 ? push_data : d1;
                    l0 <= occ == 2'd1 ? push_last : l1;
                    d1 <= push_data;
                    l1 <= push_last;
                end
                default: ;
            endcase
        end
endmodule

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: drains the FIFO in bursts onto a valid/ready stream; FIFO_RD_TIMEOUT_EN adds the partial-burst timeout
module fifo_read_ctrl
    import fifo_rd_pkg::*;
#(
    parameter int N         = 16,
    parameter int BURST_LEN = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    output logic busy,
    fifo_read_ctrl_if.master bus
);
    localparam logic [CNT_W-1:0] BL = CNT_W'(BURST_LEN);
    if (BURST_LEN < 1 || BURST_LEN > FIFO_DEPTH || TIMEOUT < 1) begin : g_bad_param
        $error("fifo_read_ctrl: BURST_LEN must be 1..%0d and TIMEOUT >= 1", FIFO_DEPTH);
    end
    state_t           state;
    logic [CNT_W-1:0] beats_left;
    logic             inflight, inflight_last;
    logic [1:0]       occ;
    logic             pop, re, go, tmo;
    assign pop = bus.m_valid && bus.m_ready;
    assign bus.m_valid = occ != 2'd0;
    assign busy = state != IDLE;
    // never more than two words between the FIFO and the consumer, counting one about to leave
    assign re = state == BURST && beats_left != '0 && !bus.fifo_empty &&
                (3'(occ) + 3'(inflight) - 3'(pop)) < 3'd2;
    assign bus.fifo_r_en = re;
    assign go = state == IDLE &&
                (bus.fifo_count >= BL || (flush && bus.fifo_count != '0) || tmo);
`ifdef FIFO_RD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt;
    assign tmo = tcnt == TW'(TIMEOUT);
    // idle cycles spent holding a partial burst, saturating at TIMEOUT
    always_ff @(posedge clk or negedge rst)
        if (!rst) tcnt <= '0;
        else if (state != IDLE || go || bus.fifo_count == '0) tcnt <= '0;
        else if (bus.fifo_count < BL && !tmo) tcnt <= tcnt + 1'b1;
`else
    assign tmo = 1'b0;
`endif
    // burst FSM: latch the burst size on entry, count issued reads, wait for the tail to drain
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state         <= IDLE;
            beats_left    <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
        end else begin
            inflight      <= re;
            inflight_last <= re && beats_left == CNT_W'(1);
            case (state)
                IDLE: if (go) begin
                    state      <= BURST;
                    beats_left <= bus.fifo_count < BL ? bus.fifo_count : BL;
                end
                BURST: begin
                    if (re) beats_left <= beats_left - 1'b1;
                    if (beats_left == '0 || (re && beats_left == CNT_W'(1))) state <= WAIT_DRAIN;
                end
                WAIT_DRAIN: if (occ == 2'd0 && !inflight) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    frc_skid_buf #(.N(N)) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight),
        .push_last (inflight_last),
        .push_data (bus.fifo_dout),
        .pop       (pop),
        .occ       (occ),
        .head_data (bus.m_data),
        .head_last (bus.m_last)
    );
endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl: directed scenarios against a behavioural 32-deep FIFO
module tb_fifo_read_ctrl;
    logic clk, rst, flush, busy, m_ready, w_en;
    logic [15:0] din;
    logic [15:0] mem [32];
    logic [4:0]  wp = '0, rp = '0;
    logic [5:0]  cnt = '0;
    logic [15:0] dout = '0;
    logic [16:0] beats [$];
    int outst = 0, empty_err = 0, ovf_err = 0;
    int tests = 0, fails = 0;

    fifo_read_ctrl_if #(.N(16)) bus ();
    fifo_read_ctrl #(.N(16), .BURST_LEN(16), .TIMEOUT(64)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );
    assign bus.fifo_empty = cnt == 6'd0;
    assign bus.fifo_count = cnt;
    assign bus.fifo_dout  = dout;
    assign bus.m_ready    = m_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO with registered dout; reads only when non-empty
    always @(posedge clk) begin
        if (w_en) begin
            mem[wp] <= din;
            wp <= wp + 5'd1;
        end
        if (bus.fifo_r_en && cnt != 6'd0) begin
            dout <= mem[rp];
            rp <= rp + 5'd1;
        end
        cnt <= cnt + 6'(w_en) - 6'(bus.fifo_r_en && cnt != 6'd0);
    end

    // stream monitor: collects beats, tracks words held or in flight
    always @(negedge clk) begin
        if (!rst) outst <= 0;
        else begin
            if (bus.m_valid && m_ready) beats.push_back({bus.m_last, bus.m_data});
            if (bus.fifo_r_en && bus.fifo_empty) empty_err <= empty_err + 1;
            if (bus.fifo_r_en && outst - int'(bus.m_valid && m_ready) >= 2) ovf_err <= ovf_err + 1;
            outst <= outst + int'(bus.fifo_r_en) - int'(bus.m_valid && m_ready);
        end
        a_no_empty_read: assert (!(bus.fifo_r_en && bus.fifo_empty))
            else $error("FAIL no_empty_read: fifo_r_en=1 while fifo_empty=1");
    end

    task automatic write_words(input logic [15:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            w_en = 1'b1;
            din = base + 16'(i);
        end
        @(posedge clk); #1;
        w_en = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_flush;
        @(posedge clk); #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        tests++; if (bus.fifo_r_en !== 1'b0) begin fails++; $display("FAIL reset_r_en: got %b want 0", bus.fifo_r_en); end
        tests++; if (bus.m_valid !== 1'b0) begin fails++; $display("FAIL reset_m_valid: got %b want 0", bus.m_valid); end
        tests++; if (bus.m_data !== 16'h0) begin fails++; $display("FAIL reset_m_data: got %h want 0000", bus.m_data); end
        tests++; if (bus.m_last !== 1'b0) begin fails++; $display("FAIL reset_m_last: got %b want 0", bus.m_last); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        @(posedge clk); #1; rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle: busy=%b want 0 with empty FIFO", busy); end
    endtask

    task automatic test_basic;
        int tb_busy = -1, tv = -1;
        bit ok;
        beats.delete();
        m_ready = 1'b1;
        write_words(16'h0001, 16);
        for (int i = 0; i < 100 && tv < 0; i++) begin
            @(negedge clk);
            if (busy && tb_busy < 0) tb_busy = i;
            if (bus.m_valid && tv < 0) tv = i;
        end
        tests++; if (tb_busy < 0 || tv - tb_busy != 2) begin fails++; $display("FAIL basic_latency: busy@%0d valid@%0d want gap 2", tb_busy, tv); end
        wait_idle(ok);
        tests++; if (!ok) begin fails++; $display("FAIL basic_idle: busy stuck high want 0"); end
        tests++; if (beats.size() != 16) begin fails++; $display("FAIL basic_beats: got %0d want 16", beats.size()); end
        for (int i = 0; i < beats.size() && i < 16; i++) begin
            tests++; if (beats[i] !== {i == 15, 16'(i + 1)}) begin fails++; $display("FAIL basic_beat%0d: got %h want %h", i, beats[i], {i == 15, 16'(i + 1)}); end
        end
        tests++; if (cnt !== 6'd0) begin fails++; $display("FAIL basic_count: fifo_count=%0d want 0", cnt); end
    endtask

    task automatic test_backpressure;
        int ovf0 = ovf_err;
        bit ok;
        beats.delete();
        m_ready = 1'b1;
        write_words(16'h0001, 16);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (beats.size() >= 3) break;
        end
        tests++; if (beats.size() != 3) begin fails++; $display("FAIL bp_reach: got %0d beats want 3", beats.size()); end
        m_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            tests++; if ({bus.m_valid, bus.m_data} !== {1'b1, 16'h0004}) begin fails++; $display("FAIL bp_hold: valid=%b data=%h want 1 0004", bus.m_valid, bus.m_data); end
        end
        @(posedge clk); #1;
        m_ready = 1'b1;
        wait_idle(ok);
        tests++; if (!ok) begin fails++; $display("FAIL bp_idle: busy stuck high want 0"); end
        tests++; if (beats.size() != 16) begin fails++; $display("FAIL bp_beats: got %0d want 16", beats.size()); end
        for (int i = 0; i < beats.size() && i < 16; i++) begin
            tests++; if (beats[i] !== {i == 15, 16'(i + 1)}) begin fails++; $display("FAIL bp_beat%0d: got %h want %h", i, beats[i], {i == 15, 16'(i + 1)}); end
        end
        tests++; if (ovf_err != ovf0) begin fails++; $display("FAIL bp_overissue: %0d reads with 2 words held want 0", ovf_err - ovf0); end
    endtask

    task automatic test_timeout;
        bit ok;
        int hit = -1;
        beats.delete();
        m_ready = 1'b1;
        write_words(16'h0A01, 3);
`ifdef FIFO_RD_TIMEOUT_EN
        // count nonzero from write edge 1, counter reaches 64 at edge 65, burst entered at edge 66 (63 edges after the third write)
        for (int i = 1; i < 200; i++) begin
            @(posedge clk); #1;
            if (busy) begin
                hit = i;
                break;
            end
        end
        tests++; if (hit != 63) begin fails++; $display("FAIL tmo_start: burst after %0d edges want 63", hit); end
`else
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (busy && hit < 0) hit = i;
        end
        tests++; if (hit >= 0 || cnt !== 6'd3) begin fails++; $display("FAIL tmo_off_hold: busy@%0d count=%0d want never, 3", hit, cnt); end
        pulse_flush();
`endif
        wait_idle(ok);
        tests++; if (!ok) begin fails++; $display("FAIL tmo_idle: busy stuck high want 0"); end
        tests++; if (beats.size() != 3) begin fails++; $display("FAIL tmo_beats: got %0d want 3", beats.size()); end
        for (int i = 0; i < beats.size() && i < 3; i++) begin
            tests++; if (beats[i] !== {i == 2, 16'h0A01 + 16'(i)}) begin fails++; $display("FAIL tmo_beat%0d: got %h want %h", i, beats[i], {i == 2, 16'h0A01 + 16'(i)}); end
        end
    endtask

    task automatic test_flush;
        bit ok;
        int hit = -1;
        beats.delete();
        m_ready = 1'b1;
        write_words(16'h0B01, 5);
        repeat (2) @(posedge clk);
        #1; flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL flush_start: busy=%b want 1 one cycle after flush", busy); end
        w_en = 1'b1; din = 16'h0B06;
        @(posedge clk); #1; din = 16'h0B07; flush = 1'b1;
        @(posedge clk); #1; w_en = 1'b0; flush = 1'b0;
        wait_idle(ok);
        tests++; if (!ok) begin fails++; $display("FAIL flush_idle: busy stuck high want 0"); end
        tests++; if (beats.size() != 5) begin fails++; $display("FAIL flush_beats: got %0d want 5", beats.size()); end
        for (int i = 0; i < beats.size() && i < 5; i++) begin
            tests++; if (beats[i] !== {i == 4, 16'h0B01 + 16'(i)}) begin fails++; $display("FAIL flush_beat%0d: got %h want %h", i, beats[i], {i == 4, 16'h0B01 + 16'(i)}); end
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && hit < 0) hit = i;
        end
        tests++; if (hit >= 0 || cnt !== 6'd2) begin fails++; $display("FAIL flush_ignored: busy@%0d count=%0d want never, 2", hit, cnt); end
        beats.delete();
        pulse_flush();
        wait_idle(ok);
        tests++; if (beats.size() != 2 || beats[0] !== {1'b0, 16'h0B06} || beats[1] !== {1'b1, 16'h0B07})
            begin fails++; $display("FAIL flush_rest: got %0d beats first %h want 2 beats 0b06,10b07", beats.size(), beats.size() ? beats[0] : 17'h0); end
        hit = -1;
        pulse_flush();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (busy && hit < 0) hit = i;
        end
        tests++; if (hit >= 0) begin fails++; $display("FAIL flush_empty: busy@%0d want stay idle", hit); end
    endtask

    task automatic test_full;
        int emp0 = empty_err;
        beats.delete();
        m_ready = 1'b1;
        write_words(16'h0C01, 32);
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (beats.size() >= 32 && !busy) break;
        end
        tests++; if (beats.size() != 32 || busy !== 1'b0) begin fails++; $display("FAIL full_beats: got %0d busy=%b want 32 0", beats.size(), busy); end
        for (int i = 0; i < beats.size() && i < 32; i++) begin
            tests++; if (beats[i] !== {i == 15 || i == 31, 16'h0C01 + 16'(i)}) begin fails++; $display("FAIL full_beat%0d: got %h want %h", i, beats[i], {i == 15 || i == 31, 16'h0C01 + 16'(i)}); end
        end
        tests++; if (empty_err != emp0 || cnt !== 6'd0) begin fails++; $display("FAIL full_empty_read: errs=%0d count=%0d want 0 0", empty_err - emp0, cnt); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        int hit = -1;
        beats.delete();
        m_ready = 1'b1;
        write_words(16'h0D01, 16);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (beats.size() >= 6) break;
        end
        rst = 1'b0;
        #1;
        tests++; if ({bus.fifo_r_en, bus.m_valid, bus.m_data, bus.m_last, busy} !== 20'h0)
            begin fails++; $display("FAIL rstmid_outputs: r_en=%b valid=%b data=%h last=%b busy=%b want all 0", bus.fifo_r_en, bus.m_valid, bus.m_data, bus.m_last, busy); end
        repeat (2) @(posedge clk);
        #1; rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy && hit < 0) hit = i;
        end
        tests++; if (hit >= 0 || cnt !== 6'd8) begin fails++; $display("FAIL rstmid_idle: busy@%0d count=%0d want never, 8", hit, cnt); end
        beats.delete();
        pulse_flush();
        wait_idle(ok);
        tests++; if (beats.size() != 8) begin fails++; $display("FAIL rstmid_beats: got %0d want 8", beats.size()); end
        for (int i = 0; i < beats.size() && i < 8; i++) begin
            tests++; if (beats[i] !== {i == 7, 16'h0D09 + 16'(i)}) begin fails++; $display("FAIL rstmid_beat%0d: got %h want %h", i, beats[i], {i == 7, 16'h0D09 + 16'(i)}); end
        end
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        m_ready = 1'b0;
        w_en = 1'b0;
        din = '0;
        #12;
        test_reset();
        test_basic();
        test_backpressure();
        test_timeout();
        test_flush();
        test_full();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
